// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op encodings, FSM states
// and the default WAIT timeout.
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        MUL = 2'b10,
        DIV = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_M = 3'd1,
        LOAD_Q = 3'd2,
        WAIT   = 3'd3,
        CAP_LO = 3'd4,
        RESP   = 3'd5,
        ABORT  = 3'd6
    } state_e;

    localparam int TIMEOUT_DEF = 255;

    // Mul and div return two bytes (high byte first), add and sub return one.
    function automatic logic is_two_byte(input op_e op);
        return (op == MUL) || (op == DIV);
    endfunction

    function automatic logic [15:0] sext8(input logic [7:0] b);
        return {{8{b[7]}}, b};
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, ALU and response signals; the arbiter uses the slave view,
// the surrounding environment the master view.
interface alu_arbiter_if;

    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_m;
    logic [15:0] req_q;

    logic        alu_rst_b;
    logic        alu_start;
    logic [1:0]  alu_s;
    logic [7:0]  alu_inbus;
    logic [7:0]  alu_outbus;
    logic        alu_finish;
    logic        alu_overflow;

    logic        rsp_valid;
    logic        rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_ovf;
    logic        rsp_timeout;

    modport slave (
        input  req_valid, req_op, req_m, req_q,
        input  alu_outbus, alu_finish, alu_overflow,
        output req_ready,
        output alu_rst_b, alu_start, alu_s, alu_inbus,
        output rsp_valid, rsp_id, rsp_data, rsp_ovf, rsp_timeout
    );

    modport master (
        output req_valid, req_op, req_m, req_q,
        output alu_outbus, alu_finish, alu_overflow,
        input  req_ready,
        input  alu_rst_b, alu_start, alu_s, alu_inbus,
        input  rsp_valid, rsp_id, rsp_data, rsp_ovf, rsp_timeout
    );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to ptr.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       advance,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (advance) begin
            unique case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one multi-cycle 8-bit ALU and returns a 16-bit
// result, an overflow flag or a timeout indication per transaction.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           rst_b,
    alu_arbiter_if.slave   bus
);

    // Counter only has to reach TIMEOUT-1; the abort decision is made on that value.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          id_q, id_d;
    op_e           op_q, op_d;
    logic [7:0]    m_q, m_d;
    logic [7:0]    q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   res_q, res_d;
    logic          ovf_q, ovf_d;

    logic [1:0]    req_ready_q, req_ready_d;
    logic          alu_rst_b_q, alu_rst_b_d;
    logic          alu_start_q, alu_start_d;
    logic [1:0]    alu_s_q, alu_s_d;
    logic [7:0]    alu_inbus_q, alu_inbus_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_id_q, rsp_id_d;
    logic [15:0]   rsp_data_q, rsp_data_d;
    logic          rsp_ovf_q, rsp_ovf_d;
    logic          rsp_timeout_q, rsp_timeout_d;

    logic [1:0]    grant;
    logic          in_idle;

    assign in_idle = (state_q == IDLE);

    rr_arb2 u_rr_arb2 (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .advance (in_idle),
        .grant   (grant)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        op_d    = op_q;
        m_d     = m_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (|grant) begin
                    id_d    = grant[1];
                    op_d    = grant[1] ? op_e'(bus.req_op[3:2]) : op_e'(bus.req_op[1:0]);
                    m_d     = grant[1] ? bus.req_m[15:8] : bus.req_m[7:0];
                    q_d     = grant[1] ? bus.req_q[15:8] : bus.req_q[7:0];
                    state_d = LOAD_M;
                end
            end
            LOAD_M: begin
                state_d = LOAD_Q;
            end
            LOAD_Q: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A finish on the final allowed cycle still completes normally.
                if (bus.alu_finish) begin
                    ovf_d = bus.alu_overflow;
                    if (is_two_byte(op_q)) begin
                        res_d[15:8] = bus.alu_outbus;
                        state_d     = CAP_LO;
                    end else begin
                        res_d   = sext8(bus.alu_outbus);
                        state_d = RESP;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ABORT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CAP_LO: begin
                res_d[7:0] = bus.alu_outbus;
                state_d    = RESP;
            end
            RESP, ABORT: begin
                ptr_d   = ~id_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered as a decode of the state being entered.
        req_ready_d   = grant;
        alu_start_d   = (state_d == LOAD_M);
        alu_s_d       = ((state_d == LOAD_M) || (state_d == LOAD_Q)) ? op_d : 2'b00;
        alu_inbus_d   = (state_d == LOAD_M) ? m_d :
                        (state_d == LOAD_Q) ? q_d : 8'h00;
        alu_rst_b_d   = (state_d != ABORT);
        rsp_valid_d   = (state_d == RESP) || (state_d == ABORT);
        rsp_id_d      = rsp_valid_d ? id_d : 1'b0;
        rsp_data_d    = (state_d == RESP) ? res_d : 16'h0000;
        rsp_ovf_d     = (state_d == RESP) ? ovf_d : 1'b0;
        rsp_timeout_d = (state_d == ABORT);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q       <= IDLE;
            ptr_q         <= 1'b0;
            id_q          <= 1'b0;
            op_q          <= ADD;
            m_q           <= 8'h00;
            q_q           <= 8'h00;
            cnt_q         <= '0;
            res_q         <= 16'h0000;
            ovf_q         <= 1'b0;
            req_ready_q   <= 2'b00;
            alu_rst_b_q   <= 1'b0;
            alu_start_q   <= 1'b0;
            alu_s_q       <= 2'b00;
            alu_inbus_q   <= 8'h00;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_data_q    <= 16'h0000;
            rsp_ovf_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            id_q          <= id_d;
            op_q          <= op_d;
            m_q           <= m_d;
            q_q           <= q_d;
            cnt_q         <= cnt_d;
            res_q         <= res_d;
            ovf_q         <= ovf_d;
            req_ready_q   <= req_ready_d;
            alu_rst_b_q   <= alu_rst_b_d;
            alu_start_q   <= alu_start_d;
            alu_s_q       <= alu_s_d;
            alu_inbus_q   <= alu_inbus_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_data_q    <= rsp_data_d;
            rsp_ovf_q     <= rsp_ovf_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.alu_rst_b   = alu_rst_b_q;
    assign bus.alu_start   = alu_start_q;
    assign bus.alu_s       = alu_s_q;
    assign bus.alu_inbus   = alu_inbus_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_ovf     = rsp_ovf_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of WAIT cycles allowed for alu_finish before an abort.
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock, rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- req_valid  in  2  request pending; bit i = requester i.
- req_ready  out  2  one-cycle grant/accept pulse per requester.
- req_op  in  4  op per requester, [2i+1:2i]; 00 add, 01 sub, 10 mul, 11 div.
- req_m  in  16  operand M per requester, [8i+7:8i].
- req_q  in  16  operand Q per requester, [8i+7:8i].
- alu_rst_b  out  1  ALU reset, active-low.
- alu_start  out  1  ALU start.
- alu_s  out  2  ALU op select.
- alu_inbus  out  8  ALU operand bus.
- alu_outbus  in  8  ALU result bus.
- alu_finish  in  1  ALU result-valid.
- alu_overflow  in  1  ALU overflow flag.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  1  index of the requester served.
- rsp_data  out  16  result.
- rsp_ovf  out  1  overflow flag.
- rsp_timeout  out  1  operation aborted.

Function
REQ-003 The block SHALL use the ALU contract below:
- Edge n: alu_start=1, alu_s=op, alu_inbus=M.
- Edge n+1: alu_start=0, alu_inbus=Q.
- Result appears on alu_outbus in the alu_finish-high cycle(s).
- Add/sub: one result byte (Q+M or Q−M).
- Mul/div: high byte (product high or remainder) on the first finish cycle, low byte (product low or quotient) on the next cycle.
REQ-004 The block SHALL implement the states IDLE, LOAD_M, LOAD_Q, WAIT, CAP_LO, RESP and ABORT.
REQ-005 In IDLE, when any req_valid bit is set, the block SHALL do the following on one edge:
- grant using round-robin;
- latch op, M and Q;
- pulse req_ready for the granted requester;
- go to LOAD_M.
REQ-006 Round-robin SHALL work as follows:
- the priority pointer resets to requester 0;
- after each RESP or ABORT, the pointer moves to the requester not just served;
- if only one requester is valid, it is granted regardless of the pointer.
REQ-007 State actions SHALL be:
- LOAD_M: drives alu_start=1, alu_s, alu_inbus=M for one cycle.
- LOAD_Q: drives alu_start=0, alu_inbus=Q for one cycle, then goes to WAIT.
REQ-008 In WAIT, on alu_finish the block SHALL capture alu_overflow into rsp_ovf, then:
- add/sub: capture alu_outbus into rsp_data[7:0], sign-extend into [15:8], go to RESP;
- mul/div: capture alu_outbus into rsp_data[15:8], go to CAP_LO.
REQ-009 CAP_LO SHALL capture alu_outbus into rsp_data[7:0] unconditionally, then go to RESP.
REQ-010 RESP SHALL assert rsp_valid for exactly one cycle with rsp_id, rsp_data, rsp_ovf and rsp_timeout=0, then return to IDLE.
REQ-011 Latency SHALL be:
- grant to rsp_valid = 3 + ALU WAIT cycles, plus 1 for mul/div;
- no back-to-back grant in the RESP cycle.
REQ-012 The WAIT counter SHALL count as follows:
- clears on entering WAIT;
- counts up once per cycle;
- when it reaches TIMEOUT without alu_finish, the block goes to ABORT.
REQ-013 ABORT SHALL, for one cycle:
- drive alu_rst_b=0;
- assert rsp_valid=1 and rsp_timeout=1 with rsp_data=0 and rsp_ovf=0;
- then go to IDLE.
REQ-014 Requester behaviour SHALL be:
- req_valid that deasserts before its grant is ignored (no response);
- a requester whose req_valid stays high after req_ready is treated as a new request.
REQ-015 When alu_finish and the timeout occur in the same cycle, alu_finish SHALL win.
REQ-016 alu_rst_b SHALL be 1 except in ABORT and while rst_b=0.
REQ-017 alu_inbus and alu_s SHALL be 0 outside LOAD_M and LOAD_Q.

Reset
REQ-018 While rst_b=0, the block SHALL hold:
- state IDLE, pointer 0, counter 0;
- all outputs 0, except alu_rst_b=0.
REQ-019 Reset mid-operation SHALL abandon the transaction with no response, and the ALU SHALL be reset through alu_rst_b.

Structure
REQ-020 A shared package SHALL hold the op encodings (ADD, SUB, MUL, DIV), the state enum and the TIMEOUT default.
REQ-021 Round-robin selection SHALL be a sub-module rr_arb2: inputs req[1:0], ptr and advance; output grant[1:0].

Verification
REQ-022 The bench SHALL cover these directed scenarios against an ALU model honouring REQ-003:
- Req0 add, M=57, Q=67 -> rsp_data=0x007C, rsp_ovf=0, rsp_id=0.
- Req1 sub, M=1, Q=0x80 -> rsp_data low byte=0x7F, rsp_ovf=1.
- Req0 mul, M=0xA3, Q=0x8D -> rsp_data=0x29C7.
- Both valid: req0 div M=13, Q=217 and req1 div M=12, Q=247 -> first rsp 0x0910 (id 0), then rsp 0x0714 (id 1).
- ALU model never asserts finish -> after TIMEOUT WAIT cycles: alu_rst_b low 1 cycle, rsp_timeout=1, then the next request is served normally.
- rst_b pulsed during WAIT -> no rsp_valid, all outputs 0 and the pointer back to 0.
